// File: rtl/proc_pkg.sv
// Package proc_pkg
//  Shared definitions for the multi-cycle control path: opcode values, FSM
//  state encoding, ALU function codes, register-destination and write-back
//  source selectors, plus small opcode-classification helpers.
//  The legal opcode set is the contiguous range OP_ADD..OP_LW, with
//  OP_STOP (all zeros) as the halt word.
package proc_pkg;

   // Opcodes, instruction bits [31:26]
   localparam logic [5:0] OP_STOP = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_OR   = 6'd4;
   localparam logic [5:0] OP_ADDI = 6'd5;
   localparam logic [5:0] OP_SLL  = 6'd6;
   localparam logic [5:0] OP_SRL  = 6'd7;
   localparam logic [5:0] OP_SLT  = 6'd8;
   localparam logic [5:0] OP_MFHI = 6'd9;
   localparam logic [5:0] OP_MFLO = 6'd10;
   localparam logic [5:0] OP_MULT = 6'd11;
   localparam logic [5:0] OP_DIV  = 6'd12;
   localparam logic [5:0] OP_BEQ  = 6'd13;
   localparam logic [5:0] OP_BNE  = 6'd14;
   localparam logic [5:0] OP_BGT  = 6'd15;
   localparam logic [5:0] OP_BLT  = 6'd16;
   localparam logic [5:0] OP_BGE  = 6'd17;
   localparam logic [5:0] OP_BLE  = 6'd18;
   localparam logic [5:0] OP_J    = 6'd19;
   localparam logic [5:0] OP_JAL  = 6'd20;
   localparam logic [5:0] OP_JR   = 6'd21;
   localparam logic [5:0] OP_SW   = 6'd22;
   localparam logic [5:0] OP_LW   = 6'd23;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_MULDIV = 3'd5,
      ST_WB     = 3'd6,
      ST_HALT   = 3'd7
   } state_t;

   // ALU function codes; ALU_NOP is what alu_op shows outside EXEC
   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR  = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   // Register-file destination select
   localparam logic [1:0] RD_RD = 2'd0;
   localparam logic [1:0] RD_RT = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   // Write-back source select
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;
   localparam logic [1:0] WB_HILO = 2'd3;

   function automatic logic op_legal(input logic [5:0] op);
      return (op >= OP_ADD) && (op <= OP_LW);
   endfunction

   function automatic logic [3:0] op_alu(input logic [5:0] op);
      logic [3:0] f;
      f = ALU_NOP;
      case (op)
         OP_ADD, OP_ADDI, OP_LW, OP_SW:                      f = ALU_ADD;
         OP_SUB, OP_BEQ, OP_BNE, OP_BGT, OP_BLT, OP_BGE, OP_BLE: f = ALU_SUB;
         OP_AND:                                             f = ALU_AND;
         OP_OR:                                              f = ALU_OR;
         OP_SLL:                                             f = ALU_SLL;
         OP_SRL:                                             f = ALU_SRL;
         OP_SLT:                                             f = ALU_SLT;
         default:                                            f = ALU_NOP;
      endcase
      return f;
   endfunction

   // Operand B comes from the sign-extended immediate (shift amounts included)
   function automatic logic op_uses_imm(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_SLL) || (op == OP_SRL) ||
             (op == OP_LW)   || (op == OP_SW);
   endfunction

   // Immediate-form ALU ops write rt; register-form ops write rd
   function automatic logic [1:0] op_reg_dst(input logic [5:0] op);
      return ((op == OP_ADDI) || (op == OP_SLL) || (op == OP_SRL)) ? RD_RT : RD_RD;
   endfunction

   function automatic logic [1:0] op_wb_sel(input logic [5:0] op);
      return ((op == OP_MFHI) || (op == OP_MFLO)) ? WB_HILO : WB_ALU;
   endfunction

endpackage

// File: rtl/comparador_desvio.sv
// Module comparador_desvio
//  Combinational branch resolution. Compares rs_dado against rt_dado as
//  signed 32-bit values and raises taken when the condition of the branch
//  opcode holds. Non-branch opcodes give taken = 0.
// Ports
//  opcode   in  6   instruction bits [31:26]
//  rs_dado  in  32  register-file read of rs
//  rt_dado  in  32  register-file read of rt
//  taken    out 1   branch condition satisfied
module comparador_desvio
   import proc_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [31:0] rs_dado,
   input  logic [31:0] rt_dado,
   output logic        taken
);

   logic signed [31:0] a_s;
   logic signed [31:0] b_s;

   assign a_s = rs_dado;
   assign b_s = rt_dado;

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  taken = (a_s == b_s);
         OP_BNE:  taken = (a_s != b_s);
         OP_BGT:  taken = (a_s >  b_s);
         OP_BLT:  taken = (a_s <  b_s);
         OP_BGE:  taken = (a_s >= b_s);
         OP_BLE:  taken = (a_s <= b_s);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Module controle_multiciclo
//  Multi-cycle control FSM. Owns the PC, latches each instruction into ir,
//  decodes opcode[31:26] and sequences ALU, register file, data memory and
//  mult/div unit through FETCH/DECODE/EXEC/MEM/MULDIV/WB. Branches and jumps
//  are resolved here. The all-zero word halts the machine until reset_n.
//  All outputs are registered.
// Configuration
//  TRAP_ILLEGAL_EN  defined: opcodes outside the legal set halt with ilegal=1.
//                   undefined: they run as a 3-cycle NOP; ilegal is tied 0.
// Parameters
//  PC_W      implemented PC bits (upper endereco_pc bits are zero), PC_W < 32
//  RESET_PC  PC loaded on reset and on start
// Ports
//  clock, reset_n          clock and asynchronous active-low reset
//  start                   IDLE -> FETCH, PC := RESET_PC
//  instrucao               instruction word at endereco_pc
//  rs_dado, rt_dado        register-file reads of rs / rt
//  mem_pronto              data-memory done
//  muldiv_pronto           mult/div done
//  endereco_pc, ir         instruction address and instruction register
//  alu_op, alu_src_imm     ALU control (alu_op nonzero only in EXEC)
//  reg_write, reg_dst,     register-file write strobe, destination and
//  wb_sel                  write-back source
//  mem_read, mem_write     held through MEM for lw / sw
//  muldiv_start            one-cycle start pulse in EXEC
//  halted, ilegal          status
module controle_multiciclo
   import proc_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int RESET_PC = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] instrucao,
   input  logic [31:0] rs_dado,
   input  logic [31:0] rt_dado,
   input  logic        mem_pronto,
   input  logic        muldiv_pronto,
   output logic [31:0] endereco_pc,
   output logic [31:0] ir,
   output logic [3:0]  alu_op,
   output logic        alu_src_imm,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_sel,
   output logic        mem_read,
   output logic        mem_write,
   output logic        muldiv_start,
   output logic        halted,
   output logic        ilegal
);

   localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

   state_t          state_reg;
   logic [PC_W-1:0] pc_reg;
   logic [31:0]     ir_reg;
   logic [3:0]      alu_op_reg;
   logic            alu_src_imm_reg;
   logic            reg_write_reg;
   logic [1:0]      reg_dst_reg;
   logic [1:0]      wb_sel_reg;
   logic            mem_read_reg;
   logic            mem_write_reg;
   logic            muldiv_start_reg;
   logic            halted_reg;

   logic [5:0]      opcode;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] imm_pc;
   logic [PC_W-1:0] branch_next;
   logic            taken;

   assign opcode   = ir_reg[31:26];
   assign pc_plus1 = pc_reg + PC_W'(1);
   // Offset truncated to PC_W bits: the add is already modulo 2**PC_W
   assign imm_pc   = PC_W'({{16{ir_reg[15]}}, ir_reg[15:0]});

   comparador_desvio u_comparador (
      .opcode  (opcode),
      .rs_dado (rs_dado),
      .rt_dado (rt_dado),
      .taken   (taken)
   );

   assign branch_next = taken ? (pc_plus1 + imm_pc) : pc_plus1;

`ifdef TRAP_ILLEGAL_EN
   logic ilegal_reg;
   assign ilegal = ilegal_reg;
`else
   assign ilegal = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_IDLE;
         pc_reg           <= RESET_PC_V;
         ir_reg           <= '0;
         alu_op_reg       <= ALU_NOP;
         alu_src_imm_reg  <= 1'b0;
         reg_write_reg    <= 1'b0;
         reg_dst_reg      <= RD_RD;
         wb_sel_reg       <= WB_ALU;
         mem_read_reg     <= 1'b0;
         mem_write_reg    <= 1'b0;
         muldiv_start_reg <= 1'b0;
         halted_reg       <= 1'b0;
`ifdef TRAP_ILLEGAL_EN
         ilegal_reg       <= 1'b0;
`endif
      end else begin
         // Strobes live for exactly the one state that sets them
         alu_op_reg       <= ALU_NOP;
         reg_write_reg    <= 1'b0;
         muldiv_start_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  pc_reg    <= RESET_PC_V;
                  state_reg <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               ir_reg          <= instrucao;
               alu_src_imm_reg <= 1'b0;
               reg_dst_reg     <= RD_RD;
               wb_sel_reg      <= WB_ALU;
               state_reg       <= ST_DECODE;
            end

            ST_DECODE: begin
               if (opcode == OP_STOP) begin
                  halted_reg <= 1'b1;
                  state_reg  <= ST_HALT;
               end
`ifdef TRAP_ILLEGAL_EN
               else if (!op_legal(opcode)) begin
                  halted_reg <= 1'b1;
                  ilegal_reg <= 1'b1;
                  state_reg  <= ST_HALT;
               end
`endif
               else begin
                  // EXEC controls are registered here so they are valid
                  // for the whole EXEC cycle
                  alu_op_reg       <= op_alu(opcode);
                  alu_src_imm_reg  <= op_uses_imm(opcode);
                  muldiv_start_reg <= (opcode == OP_MULT) || (opcode == OP_DIV);
                  state_reg        <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SLL, OP_SRL,
                  OP_SLT, OP_MFHI, OP_MFLO: begin
                     reg_write_reg <= 1'b1;
                     reg_dst_reg   <= op_reg_dst(opcode);
                     wb_sel_reg    <= op_wb_sel(opcode);
                     state_reg     <= ST_WB;
                  end
                  OP_BEQ, OP_BNE, OP_BGT, OP_BLT, OP_BGE, OP_BLE: begin
                     pc_reg    <= branch_next;
                     state_reg <= ST_FETCH;
                  end
                  OP_J: begin
                     pc_reg    <= ir_reg[PC_W-1:0];
                     state_reg <= ST_FETCH;
                  end
                  OP_JAL: begin
                     // PC is kept until the end of WB so the link value
                     // (PC+1) is still available to the datapath
                     reg_write_reg <= 1'b1;
                     reg_dst_reg   <= RD_RA;
                     wb_sel_reg    <= WB_LINK;
                     state_reg     <= ST_WB;
                  end
                  OP_JR: begin
                     pc_reg    <= rs_dado[PC_W-1:0];
                     state_reg <= ST_FETCH;
                  end
                  OP_LW: begin
                     mem_read_reg <= 1'b1;
                     state_reg    <= ST_MEM;
                  end
                  OP_SW: begin
                     mem_write_reg <= 1'b1;
                     state_reg     <= ST_MEM;
                  end
                  OP_MULT, OP_DIV: begin
                     state_reg <= ST_MULDIV;
                  end
                  default: begin
                     // Untrapped illegal opcode: behaves as a NOP
                     pc_reg    <= pc_plus1;
                     state_reg <= ST_FETCH;
                  end
               endcase
            end

            ST_MEM: begin
               if (mem_pronto) begin
                  mem_read_reg  <= 1'b0;
                  mem_write_reg <= 1'b0;
                  if (opcode == OP_LW) begin
                     reg_write_reg <= 1'b1;
                     reg_dst_reg   <= RD_RT;
                     wb_sel_reg    <= WB_MEM;
                     state_reg     <= ST_WB;
                  end else begin
                     pc_reg    <= pc_plus1;
                     state_reg <= ST_FETCH;
                  end
               end
            end

            ST_MULDIV: begin
               if (muldiv_pronto) begin
                  pc_reg    <= pc_plus1;
                  state_reg <= ST_FETCH;
               end
            end

            ST_WB: begin
               pc_reg    <= (opcode == OP_JAL) ? ir_reg[PC_W-1:0] : pc_plus1;
               state_reg <= ST_FETCH;
            end

            ST_HALT: begin
               state_reg <= ST_HALT;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign endereco_pc  = {{(32-PC_W){1'b0}}, pc_reg};
   assign ir           = ir_reg;
   assign alu_op       = alu_op_reg;
   assign alu_src_imm  = alu_src_imm_reg;
   assign reg_write    = reg_write_reg;
   assign reg_dst      = reg_dst_reg;
   assign wb_sel       = wb_sel_reg;
   assign mem_read     = mem_read_reg;
   assign mem_write    = mem_write_reg;
   assign muldiv_start = muldiv_start_reg;
   assign halted       = halted_reg;

endmodule
